// File: rtl/dcache_responder_if.sv
// dcache_responder_if: CPU load/store port and backing-memory port of the data cache.
interface dcache_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_i, we_i, byte_op_i, invalidate_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wd_i, rd_o;
    logic                  stall_o;
    logic                  mem_req_o, mem_we_o, mem_byte_op_o, mem_ack_i;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wd_o, mem_rd_i;
    logic [31:0]           hit_count_o, miss_count_o;
    modport slave (
        input  req_i, we_i, byte_op_i, addr_i, wd_i, invalidate_i, mem_ack_i, mem_rd_i,
        output rd_o, stall_o, mem_req_o, mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o,
               hit_count_o, miss_count_o
    );
    modport master (
        output req_i, we_i, byte_op_i, addr_i, wd_i, invalidate_i, mem_ack_i, mem_rd_i,
        input  rd_o, stall_o, mem_req_o, mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o,
               hit_count_o, miss_count_o
    );
endinterface

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-through no-write-allocate data cache for the memory stage.
module dcache_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 6
) (
    input logic               clk,
    input logic               rst_n_i,
    dcache_responder_if.slave bus
);
    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;
    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q [LINES];
    logic [DATA_WIDTH-1:0]  data_q [LINES];
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d, line_d, word;
    logic                   pend_q, pend_d, retry_q, retry_d;
    logic [31:0]            hit_q, hit_d, miss_q, miss_d;
    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_W-1:0]       tag;
    logic [1:0]             off;
    logic                   hit, busy, idle_req, line_we;
    assign idx = bus.addr_i[INDEX_WIDTH+1:2];
    assign tag = bus.addr_i[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign off = bus.addr_i[1:0];
    assign hit = valid_q[idx] && tag_q[idx] == tag;
    assign busy = state_q != IDLE;
    assign idle_req = !busy && bus.req_i && rst_n_i;
    // The retried load is served from the captured refill word, so a refill
    // invalidated in flight still delivers its data exactly once.
    assign word = retry_q ? rdata_q : data_q[idx];
    assign line_we = busy && bus.mem_ack_i && (state_q == REFILL || hit);
    assign bus.hit_count_o = hit_q;
    assign bus.miss_count_o = miss_q;
    always_comb begin
        line_d = data_q[idx];
        line_d[{off, 3'b000} +: 8] = bus.wd_i[7:0];
        line_d = state_q == REFILL ? bus.mem_rd_i : bus.byte_op_i ? line_d : bus.wd_i;
    end
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        pend_d = 1'b0;
        retry_d = 1'b0;
        hit_d = hit_q;
        miss_d = miss_q;
        bus.mem_req_o = busy;
        bus.mem_we_o = state_q == WRITE;
        bus.mem_byte_op_o = state_q == WRITE && bus.byte_op_i;
        bus.mem_addr_o = state_q == WRITE ? bus.addr_i : {bus.addr_i[ADDR_WIDTH-1:2], 2'b00};
        bus.mem_wd_o = state_q != WRITE ? '0 :
                       bus.byte_op_i ? {{(DATA_WIDTH-8){1'b0}}, bus.wd_i[7:0]} : bus.wd_i;
        bus.stall_o = busy || (idle_req && !retry_q && (bus.invalidate_i || bus.we_i || !hit));
        bus.rd_o = !(idle_req && !bus.we_i && (retry_q || hit)) ? '0 :
                   bus.byte_op_i ? {{(DATA_WIDTH-8){1'b0}}, word[{off, 3'b000} +: 8]} : word;
        if (busy) begin
            pend_d = pend_q | bus.invalidate_i;
            if (bus.mem_ack_i) begin
                state_d = IDLE;
                retry_d = 1'b1;
                pend_d = 1'b0;
                if (state_q == REFILL) begin
                    valid_d[idx] = 1'b1;
                    rdata_d = bus.mem_rd_i;
                end
                if (pend_q || bus.invalidate_i) valid_d = '0;
            end
        end else begin
            if (bus.invalidate_i) valid_d = '0;
            if (idle_req && !retry_q && !bus.invalidate_i) begin
                state_d = bus.we_i ? WRITE : hit ? IDLE : REFILL;
                hit_d = hit_q + 32'(!bus.we_i && hit);
                miss_d = miss_q + 32'(!bus.we_i && !hit);
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            rdata_q <= '0;
            pend_q <= 1'b0;
            retry_q <= 1'b0;
            hit_q <= '0;
            miss_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            pend_q <= pend_d;
            retry_q <= retry_d;
            hit_q <= hit_d;
            miss_q <= miss_d;
        end
    end
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx] <= tag;
            data_q[idx] <= line_d;
        end
    end
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Responder for the CPU memory-stage load/store interface.
- Direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per line.
- Sits between the pipeline's memory stage and a variable-latency backing memory, with a req/ack handshake on the memory side.
- Drives the stall the hazard logic uses to freeze the pipeline on misses and stores.

Parameters:
DATA_WIDTH, 32, word width (only 32 supported)
ADDR_WIDTH, 32, byte address width
INDEX_WIDTH, 6, log2(number of lines); tag width = ADDR_WIDTH-INDEX_WIDTH-2

Ports:
clk  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
req_i  input  1  CPU access valid this cycle
we_i  input  1  1=store, 0=load
byte_op_i  input  1  1=byte access, 0=word access
addr_i  input  ADDR_WIDTH  byte address
wd_i  input  DATA_WIDTH  store data (byte in [7:0] when byte_op_i=1)
invalidate_i  input  1  invalidate all lines
rd_o  output  DATA_WIDTH  load data
stall_o  output  1  CPU must hold the request and freeze the pipeline
mem_req_o  output  1  backing memory request
mem_we_o  output  1  backing memory write
mem_byte_op_o  output  1  backing memory byte write
mem_addr_o  output  ADDR_WIDTH  backing memory address
mem_wd_o  output  DATA_WIDTH  backing memory write data
mem_ack_i  input  1  backing memory completion (one-cycle pulse)
mem_rd_i  input  DATA_WIDTH  refill word, valid with mem_ack_i
hit_count_o  output  32  completed load hits
miss_count_o  output  32  load misses

Behaviour:
- Reset (async, rst_n_i=0):
  - State=IDLE; all valid bits=0; counters=0; pending-invalidate flag=0; retry flag=0.
  - mem_req_o=0, stall_o=0, rd_o=0.
  - Reset during REFILL or WRITE abandons the request; the backing memory must tolerate a dropped request.
- Address split: offset=addr[1:0], index=addr[INDEX_WIDTH+1:2], tag=upper bits. Hit = valid[index] && tag match.
- FSM states: IDLE, REFILL, WRITE.
- IDLE, load hit:
  - rd_o driven combinationally the same cycle, stall_o=0, zero latency.
  - Word load returns the word; byte load returns byte lane addr[1:0], zero-extended.
  - hit_count_o increments unless the retry flag is set.
- IDLE, load miss:
  - stall_o=1 combinationally.
  - Next state REFILL; miss_count_o increments.
- REFILL:
  - mem_req_o=1, mem_we_o=0, mem_addr_o={addr[ADDR_WIDTH-1:2],2'b00}, stall_o=1.
  - Outputs held stable until mem_ack_i.
  - On ack: write the line (valid=1, tag, data=mem_rd_i), set the retry flag, go to IDLE.
  - The following cycle the held request hits and is not counted; the retry flag clears.
  - Miss penalty = memory latency + 1 cycle.
- IDLE, store (hit or miss):
  - stall_o=1; next state WRITE.
- WRITE:
  - mem_req_o=1, mem_we_o=1, mem_byte_op_o=byte_op_i, mem_addr_o=addr_i (full byte address).
  - mem_wd_o=wd_i for a word store, {24'b0,wd_i[7:0]} for a byte store.
  - On ack, if the line hits: merge into the cached line (word replace, or byte lane addr[1:0] only). On a miss the cache array is unchanged.
  - After ack, go to IDLE with stall_o=0 for that cycle and no further memory request. The store is retired exactly once, tracked with the retry flag.
- CPU contract: while stall_o=1, the CPU holds req_i/we_i/byte_op_i/addr_i/wd_i stable. In REFILL and WRITE, req_i is not re-evaluated.
- Invalidate:
  - In IDLE, invalidate_i clears all valid bits at the next edge. A same-cycle request is stalled one cycle (stall_o=1), then re-evaluated and misses.
  - In REFILL or WRITE, invalidate_i sets the pending flag. Pending is applied on the cycle of return to IDLE, after any refill line write, so the refilled line is also invalid.
- Counters wrap modulo 2^32.
- req_i=0 in IDLE: stall_o=0, rd_o=0, no state change.

Test Plan:
- Reset, then load word 0x0000_0040 with memory latency 3 returning 0xDEAD_BEEF:
  - stall_o high for 4 cycles; mem_addr_o=0x40; then rd_o=0xDEAD_BEEF with stall_o=0.
  - miss_count=1, hit_count=0. A second load of 0x40 gives zero-stall rd_o=0xDEAD_BEEF and hit_count=1.
- Byte store 0xAA to 0x42 after the line above is cached:
  - mem_we_o=1, mem_byte_op_o=1, mem_addr_o=0x42, mem_wd_o=0x0000_00AA, stall until ack.
  - A word load of 0x40 then hits with 0xDEAA_BEEF; a byte load of 0x42 returns 0x0000_00AA.
- Store to an uncached 0x80 then load 0x80:
  - The store issues a memory write and no line is allocated.
  - The load misses (miss_count+1) and refills from memory.
- Conflict: load 0x40, then 0x140 (same index, INDEX_WIDTH=6):
  - Second load misses and replaces the line; reloading 0x40 misses again.
- invalidate_i asserted during a REFILL for 0x40:
  - Refill completes and the CPU gets data once.
  - The next load of 0x40 misses.
- rst_n_i pulsed low mid-REFILL:
  - mem_req_o=0 and stall_o=0 immediately, counters=0.
  - A subsequent load of a previously cached address misses.
